// File: rtl/jk_bank_pkg.sv
// jk_bank_pkg
//   Shared definitions for the JK bank scheduler: op codes carried on the
//   request interface, the J/K pin pairs they map to, the scheduler FSM
//   state encoding, and the op -> J/K decode used per bank bit.
package jk_bank_pkg;

  // Requester op codes (two bits per requester on req_op)
  localparam logic [1:0] OP_HOLD = 2'b00;
  localparam logic [1:0] OP_CLR  = 2'b01;
  localparam logic [1:0] OP_SET  = 2'b10;
  localparam logic [1:0] OP_TGL  = 2'b11;

  // J/K pin pairs, packed as {j, k}
  localparam logic [1:0] JK_HOLD = 2'b00;
  localparam logic [1:0] JK_CLR  = 2'b01;
  localparam logic [1:0] JK_SET  = 2'b10;
  localparam logic [1:0] JK_TGL  = 2'b11;

  // Scheduler sequence: one command per IDLE -> APPLY -> DONE pass
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_APPLY = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

  // Map an op onto one bank bit; bits outside the mask always hold.
  function automatic logic [1:0] op_to_jk(input logic [1:0] op, input logic sel);
    logic [1:0] jk;
    jk = JK_HOLD;
    if (sel) begin
      case (op)
        OP_HOLD: jk = JK_HOLD;
        OP_CLR:  jk = JK_CLR;
        OP_SET:  jk = JK_SET;
        OP_TGL:  jk = JK_TGL;
        default: jk = JK_HOLD;
      endcase
    end else begin
      jk = JK_HOLD;
    end
    return jk;
  endfunction

endpackage

// File: rtl/jk_ff_cell.sv
// jk_ff_cell
//   One JK flip-flop of the shared bank.
//   Ports:
//     clk  in  rising-edge clock
//     rst  in  asynchronous active-high reset, forces q to 0
//     j    in  J input
//     k    in  K input
//     q    out flop state
module jk_ff_cell
  import jk_bank_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic j,
  input  logic k,
  output logic q
);

  // JK state update: hold / clear / set / toggle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= 1'b0;
    end else begin
      case ({j, k})
        JK_HOLD: q <= q;
        JK_CLR:  q <= 1'b0;
        JK_SET:  q <= 1'b1;
        JK_TGL:  q <= ~q;
        default: q <= q;
      endcase
    end
  end

endmodule

// File: rtl/jk_bank_scheduler.sv
// jk_bank_scheduler
//   Shares one WIDTH-bit bank of JK flip-flops between NUM_REQ requesters.
//   A round-robin arbiter grants one valid requester at a time; the granted
//   op/mask is latched and driven onto the bank's J/K pins for exactly one
//   cycle, and done pulses in the following cycle when q shows the result.
//   Ports:
//     clk        in   rising-edge clock
//     rst        in   asynchronous active-high reset
//     req_valid  in   [NUM_REQ]        per-requester command valid
//     req_op     in   [2*NUM_REQ]      requester i op at [2i+1:2i]
//     req_mask   in   [WIDTH*NUM_REQ]  requester i mask at [WIDTH*i +: WIDTH]
//     req_ready  out  [NUM_REQ]        one-hot grant, only while idle
//     q          out  [WIDTH]          bank state
//     q_bar      out  [WIDTH]          ~q, combinational from the bank
//     busy       out                   sequencing a command
//     grant_id   out  [clog2(NUM_REQ)] index of the last accepted requester
//     done       out                   one-cycle pulse, result visible on q
module jk_bank_scheduler
  import jk_bank_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [2*NUM_REQ-1:0]       req_op,
  input  logic [WIDTH*NUM_REQ-1:0]   req_mask,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [WIDTH-1:0]           q,
  output logic [WIDTH-1:0]           q_bar,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       done
);

  localparam int IDW = $clog2(NUM_REQ);

  state_e           state_q, state_d;
  logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]   grant_id_q, grant_id_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] mask_q, mask_d;

  logic             win_found_s;
  logic [IDW-1:0]   win_idx_s;
  logic [1:0]       win_op_s;
  logic [WIDTH-1:0] win_mask_s;
  logic             hs_s;
  logic [WIDTH-1:0] j_s, k_s, q_s;

  // Round-robin search: first valid requester after rr_ptr, wrapping around.
  // Offsets run 1..NUM_REQ so the last winner is considered last.
  always_comb begin
    int cand;
    win_found_s = 1'b0;
    win_idx_s   = '0;
    cand        = 0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      cand = (int'(rr_ptr_q) + off) % NUM_REQ;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!win_found_s && (cand == i) && req_valid[i]) begin
          win_found_s = 1'b1;
          win_idx_s   = IDW'(i);
        end else begin
          win_found_s = win_found_s;
        end
      end
    end
  end

  // Steer the winner's op/mask and build the one-hot ready (idle only)
  always_comb begin
    win_op_s   = OP_HOLD;
    win_mask_s = '0;
    req_ready  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_idx_s == IDW'(i)) begin
        win_op_s     = req_op[2*i +: 2];
        win_mask_s   = req_mask[WIDTH*i +: WIDTH];
        req_ready[i] = (state_q == ST_IDLE) && win_found_s;
      end else begin
        req_ready[i] = 1'b0;
      end
    end
  end

  assign hs_s = (state_q == ST_IDLE) && win_found_s;

  // Next-state logic: accept in IDLE, drive bank in APPLY, report in DONE
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_id_d = grant_id_q;
    op_d       = op_q;
    mask_d     = mask_q;
    case (state_q)
      ST_IDLE: begin
        if (hs_s) begin
          state_d    = ST_APPLY;
          rr_ptr_d   = win_idx_s;
          grant_id_d = win_idx_s;
          op_d       = win_op_s;
          mask_d     = win_mask_s;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_APPLY: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // State, arbitration pointer and command latch registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      rr_ptr_q   <= IDW'(NUM_REQ - 1);
      grant_id_q <= '0;
      op_q       <= OP_HOLD;
      mask_q     <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_id_q <= grant_id_d;
      op_q       <= op_d;
      mask_q     <= mask_d;
    end
  end

  // J/K decode: latched command only during APPLY, hold everywhere else
  always_comb begin
    j_s = '0;
    k_s = '0;
    for (int b = 0; b < WIDTH; b++) begin
      if (state_q == ST_APPLY) begin
        {j_s[b], k_s[b]} = op_to_jk(op_q, mask_q[b]);
      end else begin
        {j_s[b], k_s[b]} = JK_HOLD;
      end
    end
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_cell
    jk_ff_cell u_cell (
      .clk (clk),
      .rst (rst),
      .j   (j_s[g]),
      .k   (k_s[g]),
      .q   (q_s[g])
    );
  end

  assign q        = q_s;
  assign q_bar    = ~q_s;
  assign busy     = (state_q != ST_IDLE);
  assign done     = (state_q == ST_DONE);
  assign grant_id = grant_id_q;

endmodule

// File: tb/tb_jk_bank_scheduler.sv
module tb_jk_bank_scheduler;
  import jk_bank_pkg::*;

  localparam int NR = 4;
  localparam int W  = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [NR-1:0]   req_valid;
  logic [2*NR-1:0] req_op;
  logic [W*NR-1:0] req_mask;
  logic [NR-1:0]   req_ready;
  logic [W-1:0]    q, q_bar;
  logic            busy, done;
  logic [1:0]      grant_id;

  always #5 clk = ~clk;

  jk_bank_scheduler #(.NUM_REQ(NR), .WIDTH(W)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_op(req_op),
    .req_mask(req_mask), .req_ready(req_ready), .q(q), .q_bar(q_bar),
    .busy(busy), .grant_id(grant_id), .done(done)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model (command-level) ----------------
  typedef struct { int gid; logic [W-1:0] q; } exp_t;
  exp_t         sb[$];
  int           m_phase  = 0;   // 0 idle, 1 applying, 2 result shown
  int           m_last   = NR - 1;
  int           m_hs_cnt = 0;
  int           m_hs_id  = 0;
  int           cyc      = 0;
  logic [W-1:0] m_q      = '0;
  logic [W-1:0] m_next   = '0;

  function automatic int rr_pick(input logic [NR-1:0] v, input int last);
    for (int off = 1; off <= NR; off++) begin
      if (v[(last + off) % NR]) return (last + off) % NR;
    end
    return -1;
  endfunction

  function automatic logic [W-1:0] apply_op(input logic [W-1:0] cur, input logic [1:0] op,
                                            input logic [W-1:0] m);
    case (op)
      OP_SET:  return cur | m;
      OP_CLR:  return cur & ~m;
      OP_TGL:  return cur ^ m;
      default: return cur;
    endcase
  endfunction

  initial begin : model
    int w;
    forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
        m_phase = 0;
        m_last  = NR - 1;
        m_q     = '0;
        sb.delete();
      end else if (m_phase == 0) begin
        w = rr_pick(req_valid, m_last);
        if (w >= 0) begin
          m_last  = w;
          m_next  = apply_op(m_q, req_op[2*w +: 2], req_mask[W*w +: W]);
          m_hs_id = w;
          m_hs_cnt++;
          sb.push_back('{gid: w, q: m_next});
          m_phase = 1;
        end
      end else if (m_phase == 1) begin
        m_q     = m_next;
        m_phase = 2;
      end else begin
        m_phase = 0;
      end
    end
  end

  // ---------------- monitor ----------------
  int n_done = 0;
  int gid_log[$];
  int done_cyc[$];

  initial begin : monitor
    exp_t         e;
    logic [W-1:0] nb;
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && done === 1'b1) begin
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL done_unexpected: got done=1 expected no pulse (nothing outstanding)");
        end else begin
          e  = sb.pop_front();
          nb = ~e.q;
          chk("grant_id_at_done", 32'(grant_id), 32'(e.gid));
          chk("q_at_done", 32'(q), 32'(e.q));
          chk("q_bar_at_done", 32'(q_bar), 32'(nb));
        end
        n_done++;
        gid_log.push_back(int'(grant_id));
        done_cyc.push_back(cyc);
      end
    end
  end

  // ---------------- driver ----------------
  int seen_hs    = 0;
  bit keep_valid = 1'b0;
  bit rand_en    = 1'b0;

  task automatic set_req(input int i, input logic [1:0] op, input logic [W-1:0] m);
    req_valid[i]       = 1'b1;
    req_op[2*i +: 2]   = op;
    req_mask[W*i +: W] = m;
  endtask

  task automatic rand_drive();
    for (int i = 0; i < NR; i++) begin
      if (!req_valid[i]) begin
        if ($urandom_range(0, 2) == 0)
          set_req(i, 2'($urandom_range(0, 3)), W'($urandom));
      end else if ($urandom_range(0, 9) == 0) begin
        req_valid[i] = 1'b0;  // withdraw before grant
      end else if ($urandom_range(0, 3) == 0) begin
        req_op[2*i +: 2]   = 2'($urandom_range(0, 3));
        req_mask[W*i +: W] = W'($urandom);
      end
    end
  endtask

  task automatic step();
    logic [NR-1:0] er;
    logic [W-1:0]  mqb;
    int            w;
    @(negedge clk);
    if (m_hs_cnt != seen_hs) begin
      seen_hs = m_hs_cnt;
      if (!keep_valid) req_valid[m_hs_id] = 1'b0;
    end
    if (rand_en) rand_drive();
    #1;
    er = '0;
    w  = rr_pick(req_valid, m_last);
    if (m_phase == 0 && w >= 0) er[w] = 1'b1;
    mqb = ~m_q;
    chk("req_ready", 32'(req_ready), 32'(er));
    chk("busy", 32'(busy), 32'(m_phase != 0));
    chk("done", 32'(done), 32'(m_phase == 2));
    chk("q", 32'(q), 32'(m_q));
    chk("q_bar", 32'(q_bar), 32'(mqb));
  endtask

  task automatic wait_idle();
    int k = 0;
    while ((m_phase != 0 || req_valid != '0) && k < 40) begin
      step();
      k++;
    end
    if (k >= 40) begin
      n_tests++;
      n_fail++;
      $display("FAIL wait_idle_timeout: got no idle after %0d cycles expected idle", k);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #2;
    rst       = 1'b0;
    req_valid = '0;
    seen_hs   = m_hs_cnt;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin : main
    int d0, h0, l0, k;
    int exp_order[5];
    logic [W-1:0] qprev;
    exp_order = '{0, 1, 2, 3, 0};
    rst = 1'b1; req_valid = '0; req_op = '0; req_mask = '0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;

    // 1: reset state
    @(negedge clk); #1;
    chk("t1_q", 32'(q), 32'h00);
    chk("t1_q_bar", 32'(q_bar), 32'hFF);
    chk("t1_ready", 32'(req_ready), 32'h0);
    chk("t1_busy", 32'(busy), 32'h0);
    chk("t1_done", 32'(done), 32'h0);

    // 2: req0 SET 0F
    set_req(0, OP_SET, 8'h0F);
    wait_idle();
    chk("t2_q", 32'(q), 32'h0F);
    chk("t2_gid", 32'(grant_id), 32'h0);

    // 3: req1 TOGGLE FF
    d0 = n_done;
    set_req(1, OP_TGL, 8'hFF);
    wait_idle();
    chk("t3_q", 32'(q), 32'hF0);
    chk("t3_q_bar", 32'(q_bar), 32'h0F);
    chk("t3_done_count", 32'(n_done - d0), 32'd1);

    // 4: all valid continuously, fresh arbitration
    do_reset();
    set_req(0, OP_SET, W'($urandom));
    set_req(1, OP_CLR, W'($urandom));
    set_req(2, OP_TGL, W'($urandom));
    set_req(3, OP_HOLD, W'($urandom));
    keep_valid = 1'b1;
    h0 = m_hs_cnt;
    l0 = gid_log.size();
    k  = 0;
    while (m_hs_cnt - h0 < 5 && k < 40) begin
      step();
      k++;
    end
    req_valid  = '0;
    keep_valid = 1'b0;
    seen_hs    = m_hs_cnt;
    wait_idle();
    chk("t4_grant_count", 32'(gid_log.size() - l0), 32'd5);
    if (gid_log.size() - l0 >= 5) begin
      for (int i = 0; i < 5; i++) chk("t4_grant_order", 32'(gid_log[l0+i]), 32'(exp_order[i]));
      for (int i = 0; i < 4; i++) chk("t4_spacing", 32'(done_cyc[l0+i+1] - done_cyc[l0+i]), 32'd3);
    end

    // 5: req2 CLEAR 01, reset during APPLY
    d0 = n_done;
    set_req(2, OP_CLR, 8'h01);
    @(posedge clk);
    #1 chk("t5_busy_in_apply", 32'(busy), 32'h1);
    #1 rst = 1'b1;
    #4;
    chk("t5_q", 32'(q), 32'h00);
    chk("t5_q_bar", 32'(q_bar), 32'hFF);
    chk("t5_busy", 32'(busy), 32'h0);
    chk("t5_done", 32'(done), 32'h0);
    @(posedge clk);
    #2 rst = 1'b0;
    req_valid = '0;
    seen_hs   = m_hs_cnt;
    repeat (3) step();
    chk("t5_no_done", 32'(n_done - d0), 32'd0);
    for (int i = 0; i < NR; i++) set_req(i, 2'($urandom_range(0, 3)), W'($urandom));
    h0 = m_hs_cnt;
    k  = 0;
    while (m_hs_cnt == h0 && k < 10) begin
      step();
      k++;
    end
    req_valid = '0;
    seen_hs   = m_hs_cnt;
    wait_idle();
    chk("t5_next_grant", 32'(gid_log[gid_log.size()-1]), 32'd0);

    // 6: HOLD and empty mask leave q unchanged
    qprev = m_q;
    d0 = n_done;
    set_req(3, OP_HOLD, 8'hAA);
    wait_idle();
    chk("t6_hold_q", 32'(q), 32'(qprev));
    chk("t6_hold_done", 32'(n_done - d0), 32'd1);
    d0 = n_done;
    set_req(0, 2'($urandom_range(0, 3)), 8'h00);
    wait_idle();
    chk("t6_mask0_q", 32'(q), 32'(qprev));
    chk("t6_mask0_done", 32'(n_done - d0), 32'd1);

    // random traffic against the model
    rand_en = 1'b1;
    repeat (400) step();
    rand_en   = 1'b0;
    req_valid = '0;
    wait_idle();
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
